// File: rtl/alu_forward_unit.sv
// alu_forward_unit: tag-tracking operand forwarding mux with load-use stall and saturating hit counter
module alu_forward_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_OPS = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            advance,
  input  logic                            id_valid,
  input  logic [NUM_OPS*ADDR_WIDTH-1:0]   id_src_addr,
  input  logic [NUM_OPS-1:0]              id_src_used,
  input  logic [ADDR_WIDTH-1:0]           id_dst_top_addr,
  input  logic                            id_dst_top_we,
  input  logic [ADDR_WIDTH-1:0]           id_dst_bot_addr,
  input  logic                            id_dst_bot_we,
  input  logic                            id_is_load,
  input  logic [NUM_OPS*DATA_WIDTH-1:0]   id_ex_data,
  input  logic [DATA_WIDTH-1:0]           ex_mem_top,
  input  logic [DATA_WIDTH-1:0]           ex_mem_bot,
  input  logic [DATA_WIDTH-1:0]           mem_wb_top,
  input  logic [DATA_WIDTH-1:0]           mem_wb_bot,
  input  logic                            perf_clear,
  output logic [NUM_OPS*DATA_WIDTH-1:0]   alu_data,
  output logic [NUM_OPS*5-1:0]            alu_input_sel,
  output logic                            load_use_stall,
  output logic [15:0]                     fwd_count
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  typedef struct packed {
    logic                    valid;
    logic [NUM_OPS*AW-1:0]   src;
    logic [NUM_OPS-1:0]      used;
    logic [AW-1:0]           ta;
    logic                    twe;
    logic [AW-1:0]           ba;
    logic                    bwe;
    logic                    ld;
  } ex_t;
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] ta;
    logic          twe;
    logic [AW-1:0] ba;
    logic          bwe;
  } dst_t;
  ex_t ex;
  dst_t mem, wb;
  logic [NUM_OPS-1:0] op_hit;
  function automatic logic lane_hit(logic v, logic we, logic [AW-1:0] a, logic [AW-1:0] s);
    return v && we && a == s;
  endfunction
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (advance) begin
      wb  <= mem;
      mem <= {ex.valid, ex.ta, ex.twe, ex.ba, ex.bwe};
      ex  <= (id_valid && !load_use_stall) ?
             {1'b1, id_src_addr, id_src_used, id_dst_top_addr, id_dst_top_we,
              id_dst_bot_addr, id_dst_bot_we, id_is_load} : '0;
    end
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    logic [AW-1:0] s;
    logic          u;
    logic [4:0]    sel;
    assign s   = ex.src[i*AW +: AW];
    assign u   = ex.valid && ex.used[i];
    assign sel = !u                                    ? 5'b00001 :
                 lane_hit(mem.valid, mem.twe, mem.ta, s) ? 5'b00010 :
                 lane_hit(mem.valid, mem.bwe, mem.ba, s) ? 5'b00100 :
                 lane_hit(wb.valid, wb.twe, wb.ta, s)    ? 5'b01000 :
                 lane_hit(wb.valid, wb.bwe, wb.ba, s)    ? 5'b10000 : 5'b00001;
    assign alu_input_sel[i*5 +: 5] = sel;
    assign alu_data[i*DW +: DW] = sel[1] ? ex_mem_top :
                                  sel[2] ? ex_mem_bot :
                                  sel[3] ? mem_wb_top :
                                  sel[4] ? mem_wb_bot : id_ex_data[i*DW +: DW];
    assign op_hit[i] = !sel[0];
  end
  always_comb begin
    load_use_stall = 1'b0;
    for (int i = 0; i < NUM_OPS; i++)
      load_use_stall |= id_valid && ex.valid && ex.ld && id_src_used[i] &&
                        (lane_hit(1'b1, ex.twe, ex.ta, id_src_addr[i*AW +: AW]) ||
                         lane_hit(1'b1, ex.bwe, ex.ba, id_src_addr[i*AW +: AW]));
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)
      fwd_count <= '0;
    else if (perf_clear)
      fwd_count <= '0;
    else if (advance && ex.valid && |op_hit && fwd_count != 16'hFFFF)
      fwd_count <= fwd_count + 16'd1;
endmodule

// File: tb/tb_alu_forward_unit.sv
// tb_alu_forward_unit: directed vectors checked against an instruction-history model every cycle
module tb_alu_forward_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        advance, id_valid, id_dst_top_we, id_dst_bot_we, id_is_load, perf_clear;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [4:0]  id_dst_top_addr, id_dst_bot_addr;
  logic [15:0] id_ex_data;
  logic [7:0]  ex_mem_top, ex_mem_bot, mem_wb_top, mem_wb_bot;
  logic [15:0] alu_data;
  logic [9:0]  alu_input_sel;
  logic        load_use_stall;
  logic [15:0] fwd_count;
  int n_cmp = 0;
  int n_bad = 0;
  alu_forward_unit dut (
    .clock(clock), .reset_n(reset_n), .advance(advance), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_dst_top_addr(id_dst_top_addr), .id_dst_top_we(id_dst_top_we),
    .id_dst_bot_addr(id_dst_bot_addr), .id_dst_bot_we(id_dst_bot_we),
    .id_is_load(id_is_load), .id_ex_data(id_ex_data),
    .ex_mem_top(ex_mem_top), .ex_mem_bot(ex_mem_bot),
    .mem_wb_top(mem_wb_top), .mem_wb_bot(mem_wb_bot), .perf_clear(perf_clear),
    .alu_data(alu_data), .alu_input_sel(alu_input_sel),
    .load_use_stall(load_use_stall), .fwd_count(fwd_count)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    bit            valid;
    bit [1:0][4:0] src;
    bit [1:0]      used;
    bit [4:0]      ta;
    bit            twe;
    bit [4:0]      ba;
    bit            bwe;
    bit            ld;
  } rec_t;
  rec_t      hist [3];
  bit [15:0] m_cnt = 16'd0;
  initial for (int k = 0; k < 3; k++) hist[k] = '0;
  function automatic int src_pick(int op);
    bit [4:0] s;
    bit       ok [4];
    bit [4:0] ad [4];
    if (!hist[0].valid || !hist[0].used[op]) return 0;
    s = hist[0].src[op];
    ok[0] = hist[1].valid && hist[1].twe; ad[0] = hist[1].ta;
    ok[1] = hist[1].valid && hist[1].bwe; ad[1] = hist[1].ba;
    ok[2] = hist[2].valid && hist[2].twe; ad[2] = hist[2].ta;
    ok[3] = hist[2].valid && hist[2].bwe; ad[3] = hist[2].ba;
    for (int k = 0; k < 4; k++) if (ok[k] && ad[k] == s) return k + 1;
    return 0;
  endfunction
  function automatic bit m_stall();
    bit r = 0;
    if (!id_valid || !hist[0].valid || !hist[0].ld) return 0;
    for (int op = 0; op < 2; op++)
      if (id_src_used[op] &&
          ((hist[0].twe && hist[0].ta == id_src_addr[op*5 +: 5]) ||
           (hist[0].bwe && hist[0].ba == id_src_addr[op*5 +: 5]))) r = 1;
    return r;
  endfunction
  function automatic bit [7:0] m_data(int op);
    bit [7:0] d [5];
    d[0] = id_ex_data[op*8 +: 8];
    d[1] = ex_mem_top;
    d[2] = ex_mem_bot;
    d[3] = mem_wb_top;
    d[4] = mem_wb_bot;
    return d[src_pick(op)];
  endfunction
  always @(posedge clock or negedge reset_n) begin
    bit st, hit;
    rec_t nw;
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      m_cnt = 16'd0;
    end else begin
      st  = m_stall();
      hit = src_pick(0) != 0 || src_pick(1) != 0;
      if (perf_clear) m_cnt = 16'd0;
      else if (advance && hit && m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (advance) begin
        nw = '0;
        if (id_valid && !st) begin
          nw.valid = 1;
          nw.src[0] = id_src_addr[4:0];
          nw.src[1] = id_src_addr[9:5];
          nw.used = id_src_used;
          nw.ta = id_dst_top_addr; nw.twe = id_dst_top_we;
          nw.ba = id_dst_bot_addr; nw.bwe = id_dst_bot_we;
          nw.ld = id_is_load;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = nw;
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clock) begin
    bit [9:0]  es;
    bit [15:0] ed;
    es = '0;
    for (int op = 0; op < 2; op++) es[op*5 +: 5] = 5'(1 << src_pick(op));
    ed = {m_data(1), m_data(0)};
    chk("model_sel", alu_input_sel, es);
    chk("model_data", alu_data, ed);
    chk("model_stall", load_use_stall, m_stall());
    chk("model_count", fwd_count, m_cnt);
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic set_id(input bit v, input bit [4:0] s1, input bit [4:0] s0, input bit [1:0] u,
                        input bit [4:0] ta, input bit twe, input bit [4:0] ba, input bit bwe,
                        input bit ld);
    id_valid = v; id_src_addr = {s1, s0}; id_src_used = u;
    id_dst_top_addr = ta; id_dst_top_we = twe;
    id_dst_bot_addr = ba; id_dst_bot_we = bwe; id_is_load = ld;
  endtask
  initial begin
    advance = 1'($urandom); perf_clear = 1'($urandom);
    set_id(1'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 5'($urandom),
           1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
    id_ex_data = 16'h2211;
    ex_mem_top = 8'hA5; ex_mem_bot = 8'h5A; mem_wb_top = 8'hC3; mem_wb_bot = 8'h3C;
    tick();
    tick();
    chk("reset_sel", alu_input_sel, 10'b00001_00001);
    chk("reset_data", alu_data, 16'h2211);
    chk("reset_stall", load_use_stall, 1'b0);
    chk("reset_count", fwd_count, 16'd0);
    advance = 1; perf_clear = 0;
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    reset_n = 1;
    tick();
    set_id(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    tick();
    set_id(1, 0, 3, 2'b01, 0, 0, 0, 0, 0);
    tick();
    chk("b2b_sel", alu_input_sel[4:0], 5'b00010);
    chk("b2b_data", alu_data[7:0], 8'hA5);
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    chk("b2b_count", fwd_count, 16'd1);
    set_id(1, 0, 0, 2'b00, 4, 1, 0, 0, 0);
    tick();
    set_id(1, 0, 0, 2'b00, 4, 1, 4, 1, 0);
    tick();
    set_id(1, 4, 4, 2'b11, 0, 0, 0, 0, 0);
    tick();
    chk("prio_top_sel", alu_input_sel, 10'b00010_00010);
    chk("prio_top_data", alu_data, 16'hA5A5);
    set_id(1, 0, 0, 2'b00, 4, 1, 0, 0, 0);
    tick();
    set_id(1, 0, 0, 2'b00, 4, 0, 4, 1, 0);
    tick();
    set_id(1, 4, 4, 2'b11, 0, 0, 0, 0, 0);
    tick();
    chk("prio_bot_sel", alu_input_sel, 10'b00100_00100);
    chk("prio_bot_data", alu_data, 16'h5A5A);
    set_id(1, 0, 0, 2'b00, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 0, 2'b10, 0, 0, 0, 0, 0);
    #1;
    chk("lu_stall_on", load_use_stall, 1'b1);
    tick();
    chk("lu_stall_off", load_use_stall, 1'b0);
    chk("lu_bubble_sel", alu_input_sel, 10'b00001_00001);
    tick();
    chk("lu_wb_sel", alu_input_sel, 10'b10000_00001);
    chk("lu_wb_data", alu_data, 16'h3C11);
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    advance = 0;
    repeat (3) tick();
    chk("freeze_sel", alu_input_sel, 10'b10000_00001);
    chk("freeze_count", fwd_count, 16'd3);
    #3;
    reset_n = 0;
    #1;
    chk("async_sel", alu_input_sel, 10'b00001_00001);
    chk("async_data", alu_data, 16'h2211);
    chk("async_count", fwd_count, 16'd0);
    tick();
    advance = 1;
    reset_n = 1;
    set_id(1, 0, 3, 2'b01, 3, 1, 0, 0, 0);
    tick();
    tick();
    force dut.fwd_count = 16'hFFFC;
    m_cnt = 16'hFFFC;
    #1;
    release dut.fwd_count;
    tick();
    tick();
    chk("cnt_fffe", fwd_count, 16'hFFFE);
    repeat (3) tick();
    chk("cnt_sat", fwd_count, 16'hFFFF);
    perf_clear = 1;
    tick();
    chk("cnt_clear", fwd_count, 16'd0);
    perf_clear = 0;
    tick();
    chk("cnt_after_clear", fwd_count, 16'd1);
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
